// File: rtl/tx_frame_reader_if.sv
// Transmit stream bundle between the TX frame reader and the MAC datapath.
// The master drives the word and its tags; the slave returns tx_ready.
interface tx_frame_reader_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_sop;
    logic             tx_eop;
    logic [7:0]       tx_be;

    modport master (
        output tx_data, tx_valid, tx_sop, tx_eop, tx_be,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, tx_sop, tx_eop, tx_be,
        output tx_ready
    );
endinterface

// File: rtl/tx_frame_reader.sv
// Pulls length-prefixed frames out of the TX FIFO and streams them to the MAC
// through a 2-entry skid buffer; malformed frames are drained and counted.
module tx_frame_reader #(
    parameter int WIDTH      = 64,
    parameter int MAX_LEN    = 9600,
    parameter int IFG_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_rdreq,
    input  logic [WIDTH-1:0]  fifo_q,
    input  logic              fifo_rdempty,
    tx_frame_reader_if.master tx,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       err_cnt,
    output logic              busy
);
    localparam int CW = 14;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DISCARD, IFG} state_t;
    localparam state_t GAP_STATE = (IFG_CYCLES == 0) ? IDLE : IFG;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
        logic [7:0]       be;
    } entry_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   words_reg, words_next;
    logic [CW-1:0]   issued_reg, issued_next;
    logic [CW-1:0]   recv_reg, recv_next;
    logic [7:0]      eop_be_reg, eop_be_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic            inflight_reg;
    logic [1:0]      occ_reg;
    logic            wr_ptr_reg, rd_ptr_reg;
    logic [31:0]     frame_cnt_reg;
    logic [15:0]     err_cnt_reg;

    logic            rd, err_inc, frame_inc, wr_en, pop;
    logic [15:0]     hdr_len;
    logic [CW-1:0]   hdr_words;
    logic [7:0]      hdr_be;
    entry_t          wr_entry;
    entry_t          entry [2];
    entry_t          head;

    assign hdr_len   = fifo_q[15:0];
    assign hdr_words = CW'(({1'b0, hdr_len} + 17'd7) >> 3);
    assign hdr_be    = (hdr_len[2:0] == 3'd0) ? 8'hFF : ((8'h01 << hdr_len[2:0]) - 8'h01);

    assign head        = entry[rd_ptr_reg];
    assign tx.tx_valid = (occ_reg != 2'd0);
    assign tx.tx_data  = head.data;
    assign tx.tx_sop   = head.sop;
    assign tx.tx_eop   = head.eop;
    assign tx.tx_be    = head.be;
    assign pop         = tx.tx_valid & tx.tx_ready;

    // A payload word lands on fifo_q the clock after its read request.
    assign wr_en         = inflight_reg && (state_reg == PAYLOAD);
    assign wr_entry.data = fifo_q;
    assign wr_entry.sop  = (recv_reg == '0);
    assign wr_entry.eop  = (recv_reg == words_reg - CW'(1));
    assign wr_entry.be   = wr_entry.eop ? eop_be_reg : 8'hFF;

    // Keep the request low while reset is held, even though the FSM sits in IDLE.
    assign fifo_rdreq = rd & rst_n;
    assign frame_cnt  = frame_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign busy       = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        words_next  = words_reg;
        issued_next = issued_reg;
        recv_next   = recv_reg;
        eop_be_next = eop_be_reg;
        gap_next    = gap_reg;
        rd          = 1'b0;
        err_inc     = 1'b0;
        frame_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_rdempty) begin
                    rd         = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                issued_next = '0;
                recv_next   = '0;
                words_next  = hdr_words;
                eop_be_next = hdr_be;
                if (hdr_len == 16'd0) begin
                    err_inc    = 1'b1;
                    state_next = IDLE;
                end else if (32'(hdr_len) > MAX_LEN) begin
                    err_inc    = 1'b1;
                    state_next = DISCARD;
                end else begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Never commit more words than the skid buffer can absorb.
                rd = !fifo_rdempty && (issued_reg < words_reg) &&
                     (({1'b0, occ_reg} + {2'b0, inflight_reg}) < (3'd2 + {2'b0, pop}));
                if (rd)           issued_next = issued_reg + CW'(1);
                if (inflight_reg) recv_next   = recv_reg + CW'(1);
                if (pop && head.eop) begin
                    frame_inc  = 1'b1;
                    gap_next   = '0;
                    state_next = GAP_STATE;
                end
            end
            DISCARD: begin
                rd = !fifo_rdempty && (issued_reg < words_reg);
                if (rd)           issued_next = issued_reg + CW'(1);
                if (inflight_reg) recv_next   = recv_reg + CW'(1);
                if (inflight_reg && (recv_reg == words_reg - CW'(1))) begin
                    gap_next   = '0;
                    state_next = GAP_STATE;
                end
            end
            IFG: begin
                if (gap_reg == GW'(IFG_CYCLES - 1)) state_next = IDLE;
                else                                gap_next   = gap_reg + GW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            words_reg     <= '0;
            issued_reg    <= '0;
            recv_reg      <= '0;
            eop_be_reg    <= '0;
            gap_reg       <= '0;
            inflight_reg  <= 1'b0;
            occ_reg       <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            words_reg    <= words_next;
            issued_reg   <= issued_next;
            recv_reg     <= recv_next;
            eop_be_reg   <= eop_be_next;
            gap_reg      <= gap_next;
            inflight_reg <= rd;
            occ_reg      <= occ_reg + {1'b0, wr_en} - {1'b0, pop};
            if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
            if (frame_inc) frame_cnt_reg <= frame_cnt_reg + 32'd1;
            if (err_inc && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        entry_t entry_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                               entry_reg <= '0;
            else if (wr_en && (wr_ptr_reg == 1'(gi))) entry_reg <= wr_entry;
        end
        assign entry[gi] = entry_reg;
    end
endmodule

// File: tb/tb_tx_frame_reader.sv
// Bench for tx_frame_reader: FIFO models feed two instances (IFG 2 and IFG 0);
// output beats of the main instance are scored against a queue of expected words.
module tb_tx_frame_reader;
    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [7:0]  be;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        a_rdreq, b_rdreq;
    logic [63:0] a_q, b_q;
    logic        a_empty, b_empty;
    logic [31:0] a_frame_cnt, b_frame_cnt;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic        a_busy, b_busy;

    tx_frame_reader_if a_bus ();
    tx_frame_reader_if b_bus ();

    tx_frame_reader #(.IFG_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_rdreq(a_rdreq), .fifo_q(a_q),
        .fifo_rdempty(a_empty), .tx(a_bus), .frame_cnt(a_frame_cnt),
        .err_cnt(a_err_cnt), .busy(a_busy)
    );

    tx_frame_reader #(.IFG_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_rdreq(b_rdreq), .fifo_q(b_q),
        .fifo_rdempty(b_empty), .tx(b_bus), .frame_cnt(b_frame_cnt),
        .err_cnt(b_err_cnt), .busy(b_busy)
    );

    logic [63:0] a_fifo[$];
    logic [63:0] b_fifo[$];
    beat_t       exp_q[$];

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    bit [3:0] ready_pat = 4'b1001;
    int    a_hdr_cyc = 0, a_sop_cyc = 0, a_eop_cyc = -1000, a_gap = 0;
    int    b_eop_cyc = -1000, b_gap = 0;
    int    outstanding = 0, max_out = 0, beats = 0;
    int    rd_viol = 0, stab_viol = 0;
    bit    hold_pending = 0, a_prev_valid = 0;
    beat_t held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [63:0] a_word, b_word;
        logic        a_rd, b_rd;
        beat_t       cur, e;
        a_word = '0;
        b_word = '0;
        @(negedge clk);
        a_rd = a_rdreq;
        b_rd = b_rdreq;
        if (a_rd && a_empty) rd_viol++;
        if (b_rd && b_empty) rd_viol++;
        cur = '{a_bus.tx_data, a_bus.tx_sop, a_bus.tx_eop, a_bus.tx_be};
        if (hold_pending && (!a_bus.tx_valid || cur != held)) stab_viol++;
        hold_pending = a_bus.tx_valid && !a_bus.tx_ready;
        held = cur;
        if (a_bus.tx_valid && a_bus.tx_sop && !a_prev_valid) a_sop_cyc = cyc;
        a_prev_valid = a_bus.tx_valid;
        if (a_rd && !a_busy) begin
            a_gap     = cyc - a_eop_cyc;
            a_hdr_cyc = cyc;
        end
        if (a_rd && a_busy) outstanding++;
        if (a_bus.tx_valid && a_bus.tx_ready) begin
            outstanding--;
            beats++;
            if (exp_q.size() == 0) begin
                check("a_extra_beat", a_bus.tx_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("a_data", cur.data, e.data);
                check("a_sop_eop_be", {cur.sop, cur.eop, cur.be}, {e.sop, e.eop, e.be});
                $display("beat %0d: data=%h sop=%0b eop=%0b be=%h", cyc, cur.data, cur.sop, cur.eop, cur.be);
            end
            if (a_bus.tx_eop) a_eop_cyc = cyc;
        end
        if (outstanding > max_out) max_out = outstanding;
        if (b_rd && !b_busy) b_gap = cyc - b_eop_cyc;
        if (b_bus.tx_valid && b_bus.tx_ready && b_bus.tx_eop) b_eop_cyc = cyc;
        if (a_rd && a_fifo.size() > 0) a_word = a_fifo.pop_front();
        if (b_rd && b_fifo.size() > 0) b_word = b_fifo.pop_front();
        @(posedge clk);
        #1;
        cyc++;
        if (a_rd) a_q = a_word;
        if (b_rd) b_q = b_word;
        a_empty = (a_fifo.size() == 0);
        b_empty = (b_fifo.size() == 0);
        a_bus.tx_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
    endtask

    task automatic push_frame(input bit to_b, input int len, input bit expect_out);
        logic [63:0] w;
        beat_t       e;
        int          nw;
        nw = (len + 7) / 8;
        w  = {48'hBEEF_0000_1234, 16'(len)};
        if (to_b) b_fifo.push_back(w); else a_fifo.push_back(w);
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            if (to_b) b_fifo.push_back(w); else a_fifo.push_back(w);
            if (expect_out) begin
                e.data = w;
                e.sop  = (i == 0);
                e.eop  = (i == nw - 1);
                e.be   = (i == nw - 1 && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
                exp_q.push_back(e);
            end
        end
        a_empty = (a_fifo.size() == 0);
        b_empty = (b_fifo.size() == 0);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((a_busy || b_busy || a_fifo.size() != 0 || b_fifo.size() != 0 ||
                exp_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, n < max_cyc, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        a_empty = 1'b1;
        b_empty = 1'b1;
        a_q = '0;
        b_q = '0;
        a_bus.tx_ready = 1'b1;
        b_bus.tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", a_bus.tx_valid, 1'b0);
        check("rst_frame_cnt", a_frame_cnt, 0);
        check("rst_err_cnt", a_err_cnt, 0);
        check("rst_busy", a_busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single 8-word frame, full FIFO, sink always ready.
        push_frame(0, 64, 1);
        wait_done(200, "t1_done");
        check("t1_first_valid_lat", a_sop_cyc - a_hdr_cyc, 4);
        check("t1_eop_lat", a_eop_cyc - a_hdr_cyc, 11);
        check("t1_frame_cnt", a_frame_cnt, 1);

        // Partial last word, then a single-word frame.
        push_frame(0, 13, 1);
        push_frame(0, 8, 1);
        wait_done(200, "t2_done");
        check("t2_frame_cnt", a_frame_cnt, 3);

        // Backpressure pattern 1,0,0,1.
        ready_mode = 1;
        outstanding = 0;
        max_out = 0;
        push_frame(0, 64, 1);
        wait_done(400, "t3_done");
        ready_mode = 0;
        check("t3_max_outstanding", max_out, 2);
        check("t3_hold_stable_viol", stab_viol, 0);
        check("t3_frame_cnt", a_frame_cnt, 4);

        // Zero length, oversize (1201 words drained), then a good frame.
        push_frame(0, 0, 0);
        push_frame(0, 9601, 0);
        push_frame(0, 16, 1);
        wait_done(3000, "t4_done");
        check("t4_err_cnt", a_err_cnt, 2);
        check("t4_frame_cnt", a_frame_cnt, 5);
        check("t4_fifo_drained", a_fifo.size(), 0);

        // Back-to-back frames: gap from EOP to next header read.
        push_frame(0, 24, 1);
        push_frame(0, 24, 1);
        push_frame(1, 24, 0);
        push_frame(1, 24, 0);
        wait_done(300, "t5_done");
        check("t5_gap_ifg2", a_gap, 3);
        check("t5_gap_ifg0", b_gap, 1);
        check("t5_b_frame_cnt", b_frame_cnt, 2);
        check("t5_b_err_cnt", b_err_cnt, 0);
        check("t5_a_frame_cnt", a_frame_cnt, 7);

        // Reset while word 3 of an 8-word frame is presented.
        beats = 0;
        n = 0;
        push_frame(0, 64, 1);
        while (beats < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_word3", beats, 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", a_bus.tx_valid, 1'b0);
        check("t6_rst_data", a_bus.tx_data, 64'h0);
        check("t6_rst_tags", {a_bus.tx_sop, a_bus.tx_eop, a_bus.tx_be}, 10'h0);
        check("t6_rst_rdreq", a_rdreq, 1'b0);
        check("t6_rst_frame_cnt", a_frame_cnt, 0);
        check("t6_rst_busy", a_busy, 1'b0);
        a_fifo.delete();
        exp_q.delete();
        a_empty = 1'b1;
        hold_pending = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_post_busy", a_busy, 1'b0);
        check("t6_post_frame_cnt", a_frame_cnt, 0);
        check("t6_post_valid", a_bus.tx_valid, 1'b0);

        check("rdreq_while_empty", rd_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
